// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Misses stall the pipeline through `miss`; lines move whole over a request/grant port.
module data_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN,
    parameter int MEM_ADDR_LEN  = TAG_ADDR_LEN + SET_ADDR_LEN
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [31:0]                          addr,
    input  logic                                 rd_req,
    input  logic                                 wr_req,
    input  logic [31:0]                          wr_data,
    output logic [31:0]                          rd_data,
    output logic                                 miss,
    output logic                                 mem_rd_req,
    output logic [MEM_ADDR_LEN-1:0]              mem_rd_addr,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]     mem_rd_line,
    output logic                                 mem_wr_req,
    output logic [MEM_ADDR_LEN-1:0]              mem_wr_addr,
    output logic [32*(1<<LINE_ADDR_LEN)-1:0]     mem_wr_line,
    input  logic                                 mem_gnt
);
    localparam int SETS   = 1 << SET_ADDR_LEN;
    localparam int LINE_W = 32 * (1 << LINE_ADDR_LEN);

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

    logic [LINE_ADDR_LEN-1:0] word_off;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic                     unused_byte_bits;

    assign word_off         = addr[LINE_ADDR_LEN+1:2];
    assign set_idx          = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1 -: SET_ADDR_LEN];
    assign tag              = addr[31 -: TAG_ADDR_LEN];
    assign unused_byte_bits = ^addr[1:0];

    state_t                  state_q, state_d;
    logic [SETS-1:0]         valid_q, valid_d;
    logic [SETS-1:0]         dirty_q, dirty_d;
    logic [TAG_ADDR_LEN-1:0] tag_q [SETS];
    logic [LINE_W-1:0]       line_q [SETS];
    logic [LINE_W-1:0]       fill_q, fill_d;

    logic                    mem_rd_req_q, mem_rd_req_d;
    logic                    mem_wr_req_q, mem_wr_req_d;
    logic [MEM_ADDR_LEN-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic [MEM_ADDR_LEN-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic [LINE_W-1:0]       mem_wr_line_q, mem_wr_line_d;

    // Single write port into the line/tag arrays, shared by store hits and fills.
    logic                    line_we;
    logic [LINE_W-1:0]       line_d;
    logic                    tag_we;

    logic req, hit;
    logic [LINE_W-1:0] cur_line;

    assign req      = rd_req || wr_req;
    assign cur_line = line_q[set_idx];
    assign hit      = valid_q[set_idx] && (tag_q[set_idx] == tag);

    assign miss    = (state_q != IDLE) || (req && !hit);
    assign rd_data = (state_q == IDLE && rd_req && hit) ? cur_line[{word_off, 5'b0} +: 32] : 32'd0;

    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_line = mem_wr_line_q;

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        fill_d        = fill_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_wr_req_d  = mem_wr_req_q;
        mem_rd_addr_d = mem_rd_addr_q;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_line_d = mem_wr_line_q;
        line_we       = 1'b0;
        tag_we        = 1'b0;
        line_d        = cur_line;

        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    if (wr_req) begin
                        line_d[{word_off, 5'b0} +: 32] = wr_data;
                        line_we          = 1'b1;
                        dirty_d[set_idx] = 1'b1;
                    end
                end else if (req) begin
                    if (valid_q[set_idx] && dirty_q[set_idx]) begin
                        state_d       = SWAP_OUT;
                        mem_wr_req_d  = 1'b1;
                        mem_wr_addr_d = {tag_q[set_idx], set_idx};
                        mem_wr_line_d = cur_line;
                    end else begin
                        state_d       = SWAP_IN;
                        mem_rd_req_d  = 1'b1;
                        mem_rd_addr_d = {tag, set_idx};
                    end
                end
            end
            SWAP_OUT: begin
                if (mem_gnt) begin
                    state_d       = SWAP_IN;
                    mem_wr_req_d  = 1'b0;
                    mem_rd_req_d  = 1'b1;
                    mem_rd_addr_d = {tag, set_idx};
                end
            end
            SWAP_IN: begin
                if (mem_gnt) begin
                    state_d      = SWAP_IN_OK;
                    mem_rd_req_d = 1'b0;
                    fill_d       = mem_rd_line;
                end
            end
            SWAP_IN_OK: begin
                // Request is held stable, so addr still names the set being filled.
                line_d           = fill_q;
                line_we          = 1'b1;
                tag_we           = 1'b1;
                valid_d[set_idx] = 1'b1;
                dirty_d[set_idx] = 1'b0;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            fill_q        <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_wr_addr_q <= '0;
            mem_wr_line_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            fill_q        <= fill_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_line_q <= mem_wr_line_d;
        end
    end

    // Data and tags need no reset: valid_q gates every use of them.
    always_ff @(posedge clk) begin
        if (line_we) line_q[set_idx] <= line_d;
        if (tag_we)  tag_q[set_idx]  <= tag;
    end

endmodule
